// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// The state enum is shared so the step logic and any debug taps agree on encoding.
package mult_div_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } md_state_t;

  // One extra bit so the counter can hold WIDTH-1 with headroom (6 bits at 32).
  function automatic int mdCntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration: a radix-2 Booth step or a restoring divide step.
// The accumulator is one bit wider than WIDTH so subtracting the most negative multiplicand cannot overflow.
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             isDiv,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   accNext,
  output logic [WIDTH-1:0] qNext,
  output logic             qm1Next
);

  logic [WIDTH:0] mExt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rShift;

  assign mExt   = {m[WIDTH-1], m};
  assign rShift = {acc[WIDTH-1:0], q[WIDTH-1]};

  always_comb begin
    sum     = acc;
    accNext = acc;
    qNext   = q;
    qm1Next = qm1;
    if (isDiv) begin
      // Remainder stays below the divisor magnitude, so bit WIDTH of acc is always zero here.
      qm1Next = 1'b0;
      if (rShift >= {1'b0, m}) begin
        accNext = rShift - {1'b0, m};
        qNext   = {q[WIDTH-2:0], 1'b1};
      end else begin
        accNext = rShift;
        qNext   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      case ({q[0], qm1})
        2'b01:   sum = acc + mExt;
        2'b10:   sum = acc - mExt;
        default: sum = acc;
      endcase
      accNext = {sum[WIDTH], sum[WIDTH:1]};
      qNext   = {sum[0], q[WIDTH-1:1]};
      qm1Next = q[0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth) / divide (restoring) unit with Hi/Lo result registers.
// Starts are only honoured in IDLE; Done pulses for one cycle once Hi/Lo hold the new result.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CNT_W = mdCntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_t        stateReg, stateNext;
  logic [CNT_W-1:0] cntReg;
  logic [WIDTH:0]   accReg;
  logic [WIDTH-1:0] qReg;
  logic             qm1Reg;
  logic [WIDTH-1:0] mReg;
  logic             opDivReg;
  logic             signAReg;
  logic             signBReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             divZeroReg;

  logic [WIDTH:0]   accNext;
  logic [WIDTH-1:0] qNext;
  logic             qm1Next;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] remMag;

  assign absA   = A[WIDTH-1] ? -A : A;
  assign absB   = B[WIDTH-1] ? -B : B;
  assign remMag = accReg[WIDTH-1:0];

  md_step #(.WIDTH(WIDTH)) stepInst (
    .isDiv   (opDivReg),
    .acc     (accReg),
    .q       (qReg),
    .qm1     (qm1Reg),
    .m       (mReg),
    .accNext (accNext),
    .qNext   (qNext),
    .qm1Next (qm1Next)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (MultStart)     stateNext = MULT;
        else if (DivStart) stateNext = (B == '0) ? DONE : DIV;
      end
      MULT:    if (cntReg == LAST_STEP) stateNext = FIX;
      DIV:     if (cntReg == LAST_STEP) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    Busy = (stateReg != IDLE);
    Done = (stateReg == DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cntReg     <= '0;
      accReg     <= '0;
      qReg       <= '0;
      qm1Reg     <= 1'b0;
      mReg       <= '0;
      opDivReg   <= 1'b0;
      signAReg   <= 1'b0;
      signBReg   <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      divZeroReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (MultStart) begin
            accReg   <= '0;
            qReg     <= B;
            qm1Reg   <= 1'b0;
            mReg     <= A;
            cntReg   <= '0;
            opDivReg <= 1'b0;
          end else if (DivStart) begin
            if (B == '0) begin
              divZeroReg <= 1'b1;
            end else begin
              accReg   <= '0;
              qReg     <= absA;
              qm1Reg   <= 1'b0;
              mReg     <= absB;
              signAReg <= A[WIDTH-1];
              signBReg <= B[WIDTH-1];
              cntReg   <= '0;
              opDivReg <= 1'b1;
            end
          end
        end
        MULT, DIV: begin
          accReg <= accNext;
          qReg   <= qNext;
          qm1Reg <= qm1Next;
          cntReg <= cntReg + 1'b1;
        end
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (opDivReg) begin
            loReg <= (signAReg ^ signBReg) ? -qReg : qReg;
            hiReg <= signAReg ? -remMag : remMag;
          end else begin
            hiReg <= accReg[WIDTH-1:0];
            loReg <= qReg;
          end
          divZeroReg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Hi      = hiReg;
  assign Lo      = loReg;
  assign DivZero = divZeroReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corners plus randomized back-to-back operations
// compared against plain 64-bit integer arithmetic.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        MultStart = 1'b0;
  logic        DivStart = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;
  logic        modelDz = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MultStart (MultStart),
    .DivStart  (DivStart),
    .A         (A),
    .B         (B),
    .Hi        (Hi),
    .Lo        (Lo),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  // Reference: full signed product, or truncating signed division done in 64 bits.
  task automatic model_op(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!isDiv) begin
      p = sa * sb;
      modelHi = p[63:32];
      modelLo = p[31:0];
      modelDz = 1'b0;
    end else if (b == 32'd0) begin
      modelDz = 1'b1;
    end else begin
      qv = sa / sb;
      rv = sa % sb;
      modelLo = qv[31:0];
      modelHi = rv[31:0];
      modelDz = 1'b0;
    end
  endtask

  // Entered at a negedge; returns at the negedge where Done is seen (lat = -1 on timeout).
  task automatic do_op(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busyAfter, output bit stable);
    logic [31:0] prevHi, prevLo;
    prevHi = Hi;
    prevLo = Lo;
    A = a;
    B = b;
    MultStart = !isDiv;
    DivStart = isDiv;
    @(negedge Clk);
    MultStart = 1'b0;
    DivStart = 1'b0;
    busyAfter = Busy;
    stable = 1'b1;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      if (Hi !== prevHi || Lo !== prevLo) stable = 1'b0;
      @(negedge Clk);
      lat++;
    end
    if (lat >= 100) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%b exp=0", DivZero); end
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got=%h_%h exp=0_0", Hi, Lo); end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_mult_basic();
    int lat; logic busyAfter; bit stable;
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, busyAfter, stable);
    model_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    $display("mult 7 * -3 -> Hi=%h Lo=%h lat=%0d", Hi, Lo, lat);
    checks++; if (busyAfter !== 1'b1) begin errors++; $display("FAIL mult_busy got=%b exp=1", busyAfter); end
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    checks++; if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_7x-3 got=%h_%h exp=ffffffff_ffffffeb", Hi, Lo); end
    checks++; if (Hi !== modelHi || Lo !== modelLo) begin errors++; $display("FAIL mult_model got=%h_%h exp=%h_%h", Hi, Lo, modelHi, modelLo); end
    checks++; if (!stable) begin errors++; $display("FAIL mult_hilo_stable got=changed exp=unchanged before done"); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got done=%b busy=%b exp=0 0", Done, Busy); end
  endtask

  task automatic test_mult_corner();
    int lat; logic busyAfter; bit stable;
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, busyAfter, stable);
    model_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    $display("mult min * min -> Hi=%h Lo=%h lat=%0d", Hi, Lo, lat);
    checks++; if (Hi !== 32'h4000_0000 || Lo !== 32'h0) begin errors++; $display("FAIL mult_corner got=%h_%h exp=40000000_00000000", Hi, Lo); end
    @(negedge Clk);
  endtask

  task automatic test_div_signed();
    int lat; logic busyAfter; bit stable;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, busyAfter, stable);
    model_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    $display("div -7 / 2 -> Hi=%h Lo=%h dz=%b lat=%0d", Hi, Lo, DivZero, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency got=%0d exp=33", lat); end
    checks++; if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_-7/2 got=%h_%h exp=ffffffff_fffffffd", Hi, Lo); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL div_divzero got=%b exp=0", DivZero); end
    @(negedge Clk);
  endtask

  task automatic test_div_overflow();
    int lat; logic busyAfter; bit stable;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyAfter, stable);
    model_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    $display("div min / -1 -> Hi=%h Lo=%h lat=%0d", Hi, Lo, lat);
    checks++; if (Lo !== 32'h8000_0000 || Hi !== 32'h0) begin errors++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", Hi, Lo); end
    @(negedge Clk);
  endtask

  task automatic test_div_zero();
    int lat; logic busyAfter; bit stable;
    do_op(1'b0, 32'h1234_5678, 32'd1, lat, busyAfter, stable);
    model_op(1'b0, 32'h1234_5678, 32'd1);
    @(negedge Clk);
    do_op(1'b1, 32'd99, 32'd0, lat, busyAfter, stable);
    model_op(1'b1, 32'd99, 32'd0);
    $display("div 99 / 0 -> Hi=%h Lo=%h dz=%b lat=%0d", Hi, Lo, DivZero, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL divzero_latency got=%0d exp=0", lat); end
    checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL divzero_flag got=%b exp=1", DivZero); end
    checks++; if (Lo !== 32'h1234_5678 || Hi !== modelHi) begin errors++; $display("FAIL divzero_hilo got=%h_%h exp=%h_12345678", Hi, Lo, modelHi); end
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL divzero_idle got busy=%b exp=0", Busy); end
    do_op(1'b0, 32'd5, 32'd6, lat, busyAfter, stable);
    model_op(1'b0, 32'd5, 32'd6);
    $display("mult 5 * 6 -> Hi=%h Lo=%h dz=%b lat=%0d", Hi, Lo, DivZero, lat);
    checks++; if (DivZero !== 1'b0 || Lo !== 32'd30) begin errors++; $display("FAIL divzero_clear got dz=%b lo=%h exp dz=0 lo=0000001e", DivZero, Lo); end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_op();
    bit sawDone;
    A = 32'h0BAD_F00D;
    B = 32'h0000_1234;
    MultStart = 1'b1;
    @(negedge Clk);
    MultStart = 1'b0;
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    #1;
    modelHi = '0; modelLo = '0; modelDz = 1'b0;
    $display("reset mid-mult -> Busy=%b Hi=%h Lo=%h", Busy, Hi, Lo);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", Busy); end
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got=%h_%h exp=0_0", Hi, Lo); end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) sawDone = 1'b1;
    end
    checks++; if (sawDone) begin errors++; $display("FAIL midreset_no_done got=activity exp=none"); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    A = 32'hFFFF_0101;
    B = 32'h0000_7F03;
    MultStart = 1'b1;
    @(negedge Clk);
    MultStart = 1'b0;
    model_op(1'b0, 32'hFFFF_0101, 32'h0000_7F03);
    lat = 0;
    repeat (5) begin @(negedge Clk); lat++; end
    A = 32'd17;
    B = 32'd0;
    DivStart = 1'b1;
    MultStart = 1'b1;
    @(negedge Clk);
    lat++;
    DivStart = 1'b0;
    MultStart = 1'b0;
    while (Done !== 1'b1 && lat < 100) begin @(negedge Clk); lat++; end
    $display("mult with mid-op starts -> Hi=%h Lo=%h dz=%b lat=%0d", Hi, Lo, DivZero, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    checks++; if (Hi !== modelHi || Lo !== modelLo) begin errors++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", Hi, Lo, modelHi, modelLo); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL ignore_divzero got=%b exp=0", DivZero); end
    @(negedge Clk);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd0;
      3:       v = 32'($urandom_range(0, 20));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  task automatic test_back_to_back();
    int lat, expLat; logic busyAfter; bit stable, isDiv;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      isDiv = bit'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      do_op(isDiv, a, b, lat, busyAfter, stable);
      model_op(isDiv, a, b);
      expLat = (isDiv && b == 32'd0) ? 0 : 33;
      $display("op %0d %s a=%h b=%h -> Hi=%h Lo=%h dz=%b lat=%0d", i, isDiv ? "div " : "mult", a, b, Hi, Lo, DivZero, lat);
      checks++; if (lat != expLat) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, expLat); end
      checks++; if (Hi !== modelHi || Lo !== modelLo) begin errors++; $display("FAIL b2b_result[%0d] got=%h_%h exp=%h_%h", i, Hi, Lo, modelHi, modelLo); end
      checks++; if (DivZero !== modelDz) begin errors++; $display("FAIL b2b_divzero[%0d] got=%b exp=%b", i, DivZero, modelDz); end
      checks++; if (!stable || busyAfter !== 1'b1) begin errors++; $display("FAIL b2b_busy_stable[%0d] got busy=%b stable=%0d exp=1 1", i, busyAfter, stable); end
      @(negedge Clk);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got busy=%b exp=0", i, Busy); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_corner();
    test_div_signed();
    test_div_overflow();
    test_div_zero();
    test_reset_mid_op();
    test_busy_ignore();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS multicycle processor. It consumes the A and B register outputs of the datapath and computes `mult` (radix-2 Booth) or `div` (restoring, on magnitudes, with sign fix-up) over a fixed number of cycles. Results go into internal Hi/Lo registers, which feed the `mfhi`/`mflo` path of the write-back mux. The control unit launches each operation with a one-cycle start pulse and stalls its FSM until `Done`.

## Interface
- `WIDTH`, 32, operand width; Hi and Lo are each `WIDTH` bits.
- `Clk` input 1: rising-edge clock, same clock as the datapath.
- `Reset` input 1: asynchronous, active-low reset.
- `MultStart` input 1: one-cycle pulse; start a signed multiply of `A` and `B`.
- `DivStart` input 1: one-cycle pulse; start a signed divide, `A / B`.
- `A` input `WIDTH`: operand from register A (multiplicand or dividend).
- `B` input `WIDTH`: operand from register B (multiplier or divisor).
- `Hi` output `WIDTH`: upper product, or remainder.
- `Lo` output `WIDTH`: lower product, or quotient.
- `Busy` output 1: high while the state is not IDLE.
- `Done` output 1: one-cycle pulse when Hi/Lo hold the new result.
- `DivZero` output 1: sticky flag for the last divide; high when that divide had divisor 0.

## Operation
- **States:** IDLE, MULT, DIV, FIX, DONE.
- **IDLE:**
  - `MultStart` loads A/B, clears the product register and the counter, and moves to MULT.
  - `DivStart` with B≠0 loads |A| and |B|, stores both sign bits, clears the remainder, and moves to DIV.
  - `DivStart` with B=0 sets `DivZero` and moves directly to DONE; Hi/Lo are unchanged.
  - If both starts are asserted, `MultStart` wins.
- **Start while busy:** `MultStart`/`DivStart` are ignored in every state other than IDLE.
- **MULT:** Booth step per cycle.
  - Examine {Q[0], Q₋₁}: 01 → add M to the upper half; 10 → subtract M.
  - Then arithmetic-shift {upper, Q, Q₋₁} right by one.
  - After `WIDTH` steps, go to FIX.
- **DIV:** restoring step per cycle.
  - Shift {R, Q} left by one.
  - If R ≥ |B|: R −= |B| and Q[0] = 1.
  - After `WIDTH` steps, go to FIX.
- **FIX:**
  - Multiply: Hi ← product[2W−1:W], Lo ← product[W−1:0].
  - Divide: quotient is negated when sign(A) ≠ sign(B); remainder takes the sign of A. Lo ← quotient, Hi ← remainder.
  - Any `MultStart` clears `DivZero`; any divide with nonzero divisor clears it.
  - Go to DONE.
- **DONE:** `Done` = 1 for exactly this cycle, then go to IDLE.
- **Arithmetic:**
  - Product is the full 2·`WIDTH`-bit signed product.
  - Quotient truncates toward zero.
  - 0x80000000 / −1 gives Lo = 0x80000000, Hi = 0; no trap.
- **Iteration counter:** 6 bits (for `WIDTH` = 32); terminal count is `WIDTH`−1.

## Timing
- **Reset values:**
  - Asynchronous reset (`Reset` = 0) forces IDLE with Hi = Lo = 0, `Busy` = `Done` = `DivZero` = 0.
  - This applies at any point, including mid-operation; the partial result is discarded.
- **Start sampling:** the start is sampled at edge N.
- **Normal operation (multiply, or divide with nonzero divisor):**
  - `Busy` = 1 from edge N.
  - Iteration steps occur at edges N+1 … N+`WIDTH`.
  - FIX is entered at edge N+`WIDTH`.
  - Hi/Lo update at edge N+`WIDTH`+1, and `Done` is high in the cycle that follows.
  - IDLE at edge N+`WIDTH`+2.
  - For `WIDTH` = 32, `Done` is high 33 cycles after the start edge.
- **Divide by zero:**
  - DONE at edge N, so `Done` is high in the cycle after the start.
  - `DivZero` updates at edge N.
  - IDLE at edge N+1.
- **Output stability:** Hi/Lo are registered and change only at the FIX→DONE edge and on reset.
- **Back-to-back starts:** a new start is accepted in the first IDLE cycle after DONE; there is no combinational path from start to `Busy`.

## Structure
- Shared package `mult_div_pkg`:
  - state enum `md_state_t` {IDLE, MULT, DIV, FIX, DONE};
  - `MD_WIDTH` = 32.
- One sub-module: `md_step`.
  - Combinational, single iteration.
  - Booth add/sub plus shift, or restoring compare/subtract plus shift, selected by an op bit.
  - Keeps the FSM/register module small and lets the iteration be unit-tested alone.
- The top-level module holds the FSM, counter, operand and sign registers, the Hi/Lo registers, and the sign fix-up logic.

## Test plan
- **Signed multiply:** `MultStart`, A = 7, B = −3 (0xFFFFFFFD) → `Done` 33 cycles after start; Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB.
- **Corner multiply:** A = B = 0x80000000 → Hi = 0x40000000, Lo = 0x00000000.
- **Signed divide:** `DivStart`, A = −7, B = 2 → Lo = 0xFFFFFFFD (−3), Hi = 0xFFFFFFFF (−1), `DivZero` = 0.
- **Overflow divide:** A = 0x80000000, B = −1 → Lo = 0x80000000, Hi = 0.
- **Divide by zero:** Hi/Lo preloaded by a prior mult (0x12345678 in Lo); `DivStart` with B = 0 → `Done` the next cycle, `DivZero` = 1, Hi/Lo unchanged. A following `MultStart` clears `DivZero`.
- **Reset and busy-ignore:** assert `Reset` low 10 cycles into a multiply → immediately `Busy` = 0, Hi = Lo = 0, no `Done`. Separately, pulse `DivStart` mid-multiply → ignored; the multiply result is correct.
